scfifo_valid_writer: RTL

- Producer-side front end for a single-clock show-ahead scfifo.
- Takes a ready/valid upstream stream and buffers it in a 2-entry skid.
- Issues wrreq/data toward the FIFO only when a locally tracked occupancy count shows space, so overflow checking never fires.
- Counts pops by watching the consumer's rdreq/empty pair. Provides usedw/full plus sticky error flags for the model harness.

---
 rtl/scfifo_valid_writer.sv | 109 ++++++++++
 1 files changed

// File: rtl/scfifo_valid_writer.sv
// Producer front end for a show-ahead scfifo: 2-entry skid plus a locally tracked occupancy count.
// Optional almost_full output enabled by defining SCFIFO_WR_ALMOST_FULL_EN.
module scfifo_valid_writer #(
  parameter int lpm_width    = 1,
  parameter int lpm_numwords = 128,
  parameter int lpm_widthu   = 8,
  parameter int wr_reserve   = 0
`ifdef SCFIFO_WR_ALMOST_FULL_EN
  , parameter int almost_full_value = lpm_numwords - 4
`endif
) (
  input  logic                  clock,
  input  logic                  sclr_n,
  input  logic                  in_valid,
  input  logic [lpm_width-1:0]  in_data,
  output logic                  in_ready,
  output logic                  wrreq,
  output logic [lpm_width-1:0]  data,
  input  logic                  fifo_rdreq,
  input  logic                  fifo_empty,
  output logic [lpm_widthu-1:0] usedw,
  output logic                  full,
  output logic                  almost_full,
  output logic                  wr_valid_q,
  output logic                  underflow_err,
  output logic                  overflow_err
);

  localparam logic [lpm_widthu-1:0] NUMW = lpm_widthu'(lpm_numwords);
  localparam logic [lpm_widthu-1:0] THR  = lpm_widthu'(lpm_numwords - wr_reserve);
  localparam logic [lpm_widthu-1:0] ONE  = lpm_widthu'(1);

  typedef enum logic [1:0] {IDLE, STREAM, STALL} state_t;

  logic [1:0][lpm_width-1:0] skid_q;
  logic                      rd_ptr_q, wr_ptr_q;
  logic [1:0]                cnt_q, cnt_d;
  logic [lpm_widthu-1:0]     usedw_q, usedw_d;
  logic                      full_q;
  logic                      uf_q, of_q;
  state_t                    state_q, state_d;
  logic                      accept, write, pop;

  assign in_ready      = (cnt_q != 2'd2);
  // STREAM already encodes (count != 0) & (usedw below threshold), so wrreq is a pure state decode
  assign wrreq         = (state_q == STREAM);
  assign data          = skid_q[rd_ptr_q];
  assign usedw         = usedw_q;
  assign full          = full_q;
  assign underflow_err = uf_q;
  assign overflow_err  = of_q;

  always_comb begin
    accept  = in_valid & in_ready;
    write   = wrreq;
    pop     = fifo_rdreq & ~fifo_empty;
    cnt_d   = cnt_q + {1'b0, accept} - {1'b0, write};
    usedw_d = usedw_q;
    case ({write, pop})
      2'b10:   usedw_d = (usedw_q == NUMW) ? NUMW : usedw_q + ONE;
      2'b01:   usedw_d = (usedw_q == '0) ? '0 : usedw_q - ONE;
      default: usedw_d = usedw_q;
    endcase
    if (cnt_d == 2'd0)      state_d = IDLE;
    else if (usedw_d < THR) state_d = STREAM;
    else                    state_d = STALL;
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      skid_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      usedw_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= IDLE;
      wr_valid_q <= 1'b0;
      uf_q       <= 1'b0;
      of_q       <= 1'b0;
    end else begin
      if (accept) begin
        skid_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (write) rd_ptr_q <= ~rd_ptr_q;
      cnt_q      <= cnt_d;
      usedw_q    <= usedw_d;
      full_q     <= (usedw_d == NUMW);
      state_q    <= state_d;
      wr_valid_q <= wrreq;
      if (pop && usedw_q == '0)     uf_q <= 1'b1;
      if (write && usedw_q == NUMW) of_q <= 1'b1;
    end
  end

`ifdef SCFIFO_WR_ALMOST_FULL_EN
  localparam logic [lpm_widthu-1:0] AFV = lpm_widthu'(almost_full_value);
  logic af_q;
  assign almost_full = af_q;
  always_ff @(posedge clock) begin
    if (!sclr_n) af_q <= 1'b0;
    else         af_q <= (usedw_d >= AFV);
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule
